// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first two's-complement subtractor: diff = a - b.
// One full-subtractor cell plus a borrow flip-flop, WIDTH cycles per result.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FIN   = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_n;
    logic [CW-1:0]    cnt;
    logic             bq;
    logic             bq_n;
    logic             d;
    logic             a_msb;
    logic             b_msb;

    always_comb begin
        d     = sa[0] ^ sb[0] ^ bq;
        bq_n  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bq);
        res_n = res >> 1;
        res_n[WIDTH-1] = d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            cnt    <= '0;
            bq     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            unique case (state)
                IDLE, FIN: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        bq    <= 1'b0;
                        cnt   <= CW'(WIDTH - 1);
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= res_n;
                    bq  <= bq_n;
                    if (cnt == '0) begin
                        // Results land on the edge entering FIN.
                        diff   <= res_n;
                        borrow <= bq_n;
                        ovf    <= (a_msb != b_msb) &&
                                  (res_n[WIDTH-1] != a_msb);
                        state  <= FIN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready = (state == IDLE) || (state == FIN);
    assign busy  = (state == SHIFT);
    assign done  = (state == FIN);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an arithmetic reference model checked every
// cycle on a WIDTH=8 and a WIDTH=1 instance, plus literal result checks.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       ready8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       borrow8;
    logic       ovf8;
    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       ready1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       borrow1;
    logic       ovf1;

    int vectors = 0;
    int miscompares = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8),
        .diff(diff8), .borrow(borrow8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .ready(ready1), .busy(busy1), .done(done1),
        .diff(diff1), .borrow(borrow1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: unsigned wrap, unsigned borrow, signed range.
    task automatic calc(input int w, input longint pa, input longint pb,
                        output longint d, output bit br, output bit ov);
        longint m;
        longint xa;
        longint xb;
        longint r;
        m  = longint'(1) << w;
        d  = (pa - pb + m) % m;
        br = pa < pb;
        xa = (pa >= m / 2) ? pa - m : pa;
        xb = (pb >= m / 2) ? pb - m : pb;
        r  = xa - xb;
        ov = (r < -(m / 2)) || (r > m / 2 - 1);
    endtask

    int     rem[2] = '{0, 0};
    bit     mdone[2] = '{0, 0};
    longint pa[2] = '{0, 0};
    longint pb[2] = '{0, 0};
    longint md[2] = '{0, 0};
    bit     mb[2] = '{0, 0};
    bit     mo[2] = '{0, 0};

    task automatic mstep(input int i, input int w, input bit r,
                         input bit st, input longint av, input longint bv);
        longint td;
        bit     tb;
        bit     to;
        if (r) begin
            rem[i] = 0; mdone[i] = 0;
            md[i] = 0; mb[i] = 0; mo[i] = 0;
        end else if (rem[i] > 0) begin
            rem[i]--;
            mdone[i] = (rem[i] == 0);
            if (mdone[i]) begin
                calc(w, pa[i], pb[i], td, tb, to);
                md[i] = td; mb[i] = tb; mo[i] = to;
            end
        end else begin
            mdone[i] = 0;
            if (st) begin
                rem[i] = w; pa[i] = av; pb[i] = bv;
            end
        end
    endtask

    always @(posedge clk) begin
        mstep(0, 8, rst, start8, longint'(a8), longint'(b8));
        mstep(1, 1, rst, start1, longint'(a1), longint'(b1));
        #1;
        chk("w8_ready", ready8, rem[0] == 0);
        chk("w8_busy", busy8, rem[0] > 0);
        chk("w8_done", done8, mdone[0]);
        chk("w8_diff", diff8, md[0][7:0]);
        chk("w8_borrow", borrow8, mb[0]);
        chk("w8_ovf", ovf8, mo[0]);
        chk("w1_ready", ready1, rem[1] == 0);
        chk("w1_busy", busy1, rem[1] > 0);
        chk("w1_done", done1, mdone[1]);
        chk("w1_diff", diff1, md[1][0:0]);
        chk("w1_borrow", borrow1, mb[1]);
        chk("w1_ovf", ovf1, mo[1]);
    end

    task automatic wait_done(input int which, input int budget,
                             output int cyc);
        logic seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc <= budget) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = (which == 0) ? done8 : done1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_done: no done within %0d cycles", budget);
        end
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ed, input logic eb,
                       input logic eo);
        int cyc;
        @(negedge clk);
        a8 = av; b8 = bv; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'hEE; b8 = 8'h77;
        wait_done(0, 20, cyc);
        chk("op8_latency", cyc, 8);
        chk("op8_diff", diff8, ed);
        chk("op8_borrow", borrow8, eb);
        chk("op8_ovf", ovf8, eo);
        chk("op8_ready", ready8, 1'b1);
    endtask

    logic [7:0] qa[4] = '{8'h10, 8'h01, 8'h80, 8'hC8};
    logic [7:0] qb[4] = '{8'h01, 8'h02, 8'h7F, 8'h38};
    logic [7:0] qd[4] = '{8'h0F, 8'hFF, 8'h01, 8'h90};
    logic       qbr[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       qov[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int cyc;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        chk("reset_diff", diff8, 8'h00);
        chk("reset_ready", ready8, 1'b1);
        rst = 1'b0;

        op8(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
        op8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        op8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Starts during SHIFT cycles 3 and 5 must be ignored.
        @(negedge clk);
        a8 = 8'h44; b8 = 8'h11; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done(0, 20, cyc);
        chk("ignore_diff", diff8, 8'h33);
        chk("ignore_borrow", borrow8, 1'b0);
        repeat (3) @(negedge clk);

        // Back-to-back with start held high.
        @(negedge clk);
        a8 = qa[0]; b8 = qb[0]; start8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_done(0, 20, cyc);
            chk("b2b_period", cyc, 9);
            chk("b2b_diff", diff8, qd[i]);
            chk("b2b_borrow", borrow8, qbr[i]);
            chk("b2b_ovf", ovf8, qov[i]);
            @(negedge clk);
            if (i < 3) begin
                a8 = qa[i+1]; b8 = qb[i+1];
            end else begin
                start8 = 1'b0;
            end
        end
        repeat (2) @(negedge clk);

        // Reset during SHIFT cycle 4.
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h11; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_diff", diff8, 8'h00);
        chk("rst_borrow", borrow8, 1'b0);
        chk("rst_ovf", ovf8, 1'b0);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_ready", ready8, 1'b1);
        chk("rst_done", done8, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        op8(8'h03, 8'h03, 8'h00, 1'b0, 1'b0);

        // WIDTH=1 instance.
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1, 10, cyc);
        chk("w1_latency", cyc, 1);
        chk("w1a_diff", diff1, 1'b1);
        chk("w1a_borrow", borrow1, 1'b1);
        chk("w1a_ovf", ovf1, 1'b1);
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1, 10, cyc);
        chk("w1b_diff", diff1, 1'b0);
        chk("w1b_borrow", borrow1, 1'b0);
        chk("w1b_ovf", ovf1, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial, LSB-first two's-complement subtractor that computes a - b using one full-subtractor cell and a borrow flip-flop. It is the inverse-direction arithmetic counterpart to the team's ripple full-adder datapath. It trades latency for area. Operands are captured on a start pulse, and the result is presented with a one-cycle done strobe. The block sits beside the adder in the arithmetic unit and is used where a narrow, low-area subtract is preferred over a ripple chain.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1 to 32).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request to begin; sampled only when ready=1.
a  input  WIDTH  minuend; captured on an accepted start.
b  input  WIDTH  subtrahend; captured on an accepted start.
ready  output  1  high when a start will be accepted (state IDLE or DONE).
busy  output  1  high while bits are being processed (state SHIFT).
done  output  1  one-cycle strobe; diff/borrow/ovf are newly valid.
diff  output  WIDTH  (a - b) mod 2^WIDTH; registered and held.
borrow  output  1  unsigned borrow-out; 1 iff a < b unsigned.
ovf  output  1  signed overflow of a - b.

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-operation):
  - state goes to IDLE.
  - diff=0, borrow=0, ovf=0, done=0, busy=0, ready=1.
  - Internal shift registers, bit counter and borrow flip-flop all clear.
  - Any in-flight operation is discarded with no done strobe.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if start=1, capture a into the A shift register and b into the B shift register, clear the borrow FF, load the counter with WIDTH-1, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each cycle, process one bit.
    - d_i = A[0] ^ B[0] ^ bq.
    - bq_next = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & bq).
    - Shift A and B right by one.
    - Shift d_i into the MSB of the result shift register.
    - When counter == 0, go to DONE. Otherwise decrement the counter.
  - DONE: for this one cycle, done=1.
    - diff, borrow and ovf are loaded on the edge entering DONE, so they are valid in the same cycle as done.
    - Next state is SHIFT if start=1 (operands captured exactly as in IDLE), otherwise IDLE.
- Output encoding: busy=1 only in SHIFT; ready=1 in IDLE and DONE.
- Latency: start accepted at edge E0 → busy for exactly WIDTH cycles → done high in the cycle following the (WIDTH)th edge after E0. Issue interval is WIDTH+1 cycles when start is held high.
- Result assembly:
  - diff = final result shift register contents.
  - borrow = final borrow FF value.
  - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the captured operands. The MSB sign bits are registered at capture.
- Holding: diff, borrow and ovf hold their values until the next DONE. They do not change during a subsequent SHIFT.
- Start handling:
  - start while busy=1 is ignored, with no effect on the operation in progress.
  - The a and b inputs are don't-care except on an accepted start.
- WIDTH=1: the counter is 0 at load, giving exactly one SHIFT cycle.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset, then WIDTH=8, a=0x5A, b=0x23, start pulse → busy for 8 cycles, then done=1 with diff=0x37, borrow=0, ovf=0; ready=1 in the done cycle.
2. a=0x00, b=0x01 → diff=0xFF, borrow=1, ovf=0. Then a=0x80, b=0x01 → diff=0x7F, borrow=0, ovf=1. Then a=0x7F, b=0xFF → diff=0x80, borrow=1, ovf=1.
3. start re-asserted with a=0x10, b=0x20 on cycles 3 and 5 of a busy operation → ignored; the first result is unaffected and only one done is produced.
4. start held high continuously with new operands presented on each done cycle → a done every 9 cycles with correct results; diff holds the previous result throughout each SHIFT.
5. rst=1 during SHIFT cycle 4 → next cycle diff=0, borrow=0, ovf=0, busy=0, ready=1, with no done strobe. A following a=0x03, b=0x03 operation gives diff=0x00, borrow=0.
6. WIDTH=1 build: a=0, b=1 → busy for 1 cycle, then done with diff=1, borrow=1, ovf=1. a=1, b=1 → diff=0, borrow=0, ovf=0.
